// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between an ALU writeback
// source (A) and a memory/long-latency writeback source (B). Round-robin
// arbitration with valid/ready handshakes, a registered write stage, and a
// per-register busy scoreboard for the hazard unit.
module rf_wb_arbiter #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  // Source A: ALU/EX writeback
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_sel,
  input  logic [DW-1:0]   a_dat,
  // Source B: memory/long-latency writeback
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_sel,
  input  logic [DW-1:0]   b_dat,
  // Issue-stage reservations
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_sel,
  input  logic            flush,
  // Register file write port
  output logic            rf_wen,
  output logic [AW-1:0]   rf_wsel,
  output logic [DW-1:0]   rf_wdat,
  output logic [NREG-1:0] busy
);

  // Which source was granted most recently.
  typedef enum logic [0:0] {
    StLastA,
    StLastB
  } state_e;

  state_e          r_state_q, r_state_d;

  logic            w_grant_a, w_grant_b;
  logic            w_acc_a, w_acc_b, w_acc_any;
  logic [AW-1:0]   w_acc_sel;
  logic [DW-1:0]   w_acc_dat;
  logic            w_acc_sel_ok;
  logic            w_rsv_ok;

  logic            r_wen_q, r_wen_d;
  logic [AW-1:0]   r_wsel_q, r_wsel_d;
  logic [DW-1:0]   r_wdat_q, r_wdat_d;
  logic [NREG-1:0] r_busy_q, r_busy_d;

  // Round-robin grant: on a tie the source not granted last wins.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (a_valid && b_valid) begin
      w_grant_a = (r_state_q == StLastB);
      w_grant_b = (r_state_q == StLastA);
    end else begin
      w_grant_a = a_valid;
      w_grant_b = b_valid;
    end
  end

  // A flush suppresses both readies so nothing is accepted that cycle.
  assign a_ready = w_grant_a & ~flush;
  assign b_ready = w_grant_b & ~flush;

  assign w_acc_a   = a_valid & a_ready;
  assign w_acc_b   = b_valid & b_ready;
  assign w_acc_any = w_acc_a | w_acc_b;
  assign w_acc_sel = w_acc_a ? a_sel : b_sel;
  assign w_acc_dat = w_acc_a ? a_dat : b_dat;

  // Register 0 and out-of-range selects complete the handshake but never write.
  assign w_acc_sel_ok = (w_acc_sel != '0) && (32'(w_acc_sel) < NREG);
  assign w_rsv_ok     = rsv_en && (rsv_sel != '0) && (32'(rsv_sel) < NREG);

  // FSM next state: follow the accepted source, hold otherwise (incl. flush).
  always_comb begin
    r_state_d = r_state_q;
    if (w_acc_a) begin
      r_state_d = StLastA;
    end else if (w_acc_b) begin
      r_state_d = StLastB;
    end
  end

  // Write stage next state: select/data hold unless a new write is accepted.
  always_comb begin
    r_wen_d  = 1'b0;
    r_wsel_d = r_wsel_q;
    r_wdat_d = r_wdat_q;
    if (w_acc_any) begin
      r_wen_d  = w_acc_sel_ok;
      r_wsel_d = w_acc_sel;
      r_wdat_d = w_acc_dat;
    end
    if (flush) begin
      r_wen_d = 1'b0;
    end
  end

  // Scoreboard next state: landing write clears, reservation sets (set wins).
  always_comb begin
    r_busy_d = r_busy_q;
    if (flush) begin
      r_busy_d = '0;
    end else begin
      if (r_wen_q && (32'(r_wsel_q) < NREG)) begin
        r_busy_d[r_wsel_q] = 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy_d[rsv_sel] = 1'b1;
      end
    end
    r_busy_d[0] = 1'b0;
  end

  // State registers; reset makes A win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= StLastB;
      r_wen_q   <= 1'b0;
      r_wsel_q  <= '0;
      r_wdat_q  <= '0;
      r_busy_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_wen_q   <= r_wen_d;
      r_wsel_q  <= r_wsel_d;
      r_wdat_q  <= r_wdat_d;
      r_busy_q  <= r_busy_d;
    end
  end

  assign rf_wen  = r_wen_q;
  assign rf_wsel = r_wsel_q;
  assign rf_wdat = r_wdat_q;
  assign busy    = r_busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scenario tasks plus a per-cycle scoreboard monitor that
// models arbitration, the write stage and the busy scoreboard independently.
module tb_rf_wb_arbiter;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  typedef struct packed {
    logic          acc;
    logic          wen;
    logic [AW-1:0] sel;
    logic [DW-1:0] dat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [AW-1:0]   a_sel, b_sel;
  logic [DW-1:0]   a_dat, b_dat;
  logic            rsv_en;
  logic [AW-1:0]   rsv_sel;
  logic            flush;
  logic            rf_wen;
  logic [AW-1:0]   rf_wsel;
  logic [DW-1:0]   rf_wdat;
  logic [NREG-1:0] busy;

  int total = 0;
  int bad   = 0;

  // Scoreboard and reference model state (monitor only).
  exp_t            sbq[$];
  exp_t            m_e;
  exp_t            m_push;
  logic            m_last;  // 0 = A granted last, 1 = B granted last
  logic [NREG-1:0] m_busy;
  logic [AW-1:0]   m_wsel;
  logic [DW-1:0]   m_wdat;
  logic            m_ea, m_eb;

  rf_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_sel   (a_sel),
    .a_dat   (a_dat),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_sel   (b_sel),
    .b_dat   (b_dat),
    .rsv_en  (rsv_en),
    .rsv_sel (rsv_sel),
    .flush   (flush),
    .rf_wen  (rf_wen),
    .rf_wsel (rf_wsel),
    .rf_wdat (rf_wdat),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: pop this cycle's expectation, check, then push the next.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_last = 1'b1;
      m_busy = '0;
      m_wsel = '0;
      m_wdat = '0;
    end else begin
      if (sbq.size() > 0) m_e = sbq.pop_front();
      else m_e = '0;
      if (m_e.acc) begin
        m_wsel = m_e.sel;
        m_wdat = m_e.dat;
      end
      total++;
      if (rf_wen !== m_e.wen) begin
        bad++;
        $display("FAIL mon_wen t=%0t got=%0b exp=%0b", $time, rf_wen, m_e.wen);
      end
      total++;
      if (rf_wsel !== m_wsel || rf_wdat !== m_wdat) begin
        bad++;
        $display("FAIL mon_wdata t=%0t got=%0d/%h exp=%0d/%h", $time, rf_wsel, rf_wdat,
                 m_wsel, m_wdat);
      end
      total++;
      if (busy !== m_busy) begin
        bad++;
        $display("FAIL mon_busy t=%0t got=%h exp=%h", $time, busy, m_busy);
      end
      m_ea = a_valid && !flush && (!b_valid || m_last == 1'b1);
      m_eb = b_valid && !flush && (!a_valid || m_last == 1'b0);
      total++;
      if (a_ready !== m_ea || b_ready !== m_eb) begin
        bad++;
        $display("FAIL mon_ready t=%0t got=%0b%0b exp=%0b%0b", $time, a_ready, b_ready,
                 m_ea, m_eb);
      end
      if (m_ea) begin
        m_push = {1'b1, (a_sel != '0), a_sel, a_dat};
        sbq.push_back(m_push);
        m_last = 1'b0;
      end else if (m_eb) begin
        m_push = {1'b1, (b_sel != '0), b_sel, b_dat};
        sbq.push_back(m_push);
        m_last = 1'b1;
      end
      if (flush) begin
        m_busy = '0;
      end else begin
        if (m_e.wen) m_busy[m_e.sel] = 1'b0;
        if (rsv_en && rsv_sel != '0) m_busy[rsv_sel] = 1'b1;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 0; b_valid = 0; a_sel = 0; b_sel = 0; a_dat = 0; b_dat = 0;
    rsv_en = 0; rsv_sel = 0; flush = 0;
    repeat (3) tick();
    total++;
    if (rf_wen !== 1'b0 || rf_wsel !== '0 || rf_wdat !== '0 || busy !== '0) begin
      bad++;
      $display("FAIL reset_init got=%0b/%0d/%h/%h exp=0/0/0/0", rf_wen, rf_wsel, rf_wdat, busy);
    end
    rst = 1'b0;
    // Get a write in flight and a reservation outstanding, then reset mid-cycle.
    a_valid = 1; a_sel = 2; a_dat = 32'h0000_1234; rsv_en = 1; rsv_sel = 4;
    tick();
    a_valid = 0; rsv_en = 0;
    total++;
    if (rf_wen !== 1'b1 || busy[4] !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre got=%0b/%0b exp=1/1", rf_wen, busy[4]);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (rf_wen !== 1'b0 || busy !== '0) begin
      bad++;
      $display("FAIL reset_async got=%0b/%h exp=0/0", rf_wen, busy);
    end
    tick();
    rst = 1'b0;
    a_valid = 1; a_sel = 3; b_valid = 1; b_sel = 5;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_tie got=%0b%0b exp=10", a_ready, b_ready);
    end
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_tie();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_valid = 1; a_sel = 3; a_dat = 32'hAAAA_0001;
    b_valid = 1; b_sel = 5; b_dat = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL tie_grant%0d got=%0b%0b exp=%0b%0b", i, a_ready, b_ready,
                 (i % 2 == 0), (i % 2 == 1));
      end
      tick();
      total++;
      if (rf_wen !== 1'b1 || rf_wsel !== ((i % 2 == 0) ? 5'd3 : 5'd5)) begin
        bad++;
        $display("FAIL tie_wsel%0d got=%0b/%0d exp=1/%0d", i, rf_wen, rf_wsel,
                 (i % 2 == 0) ? 3 : 5);
      end
    end
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_single();
    b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b_sel = AW'(7 + i);
      b_dat = 32'hC0DE_0000 + i;
      #1;
      total++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
        bad++;
        $display("FAIL single_ready%0d got=%0b%0b exp=01", i, a_ready, b_ready);
      end
      tick();
      total++;
      if (rf_wen !== 1'b1 || rf_wsel !== AW'(7 + i) || rf_wdat !== 32'hC0DE_0000 + i) begin
        bad++;
        $display("FAIL single_wr%0d got=%0b/%0d/%h exp=1/%0d/%h", i, rf_wen, rf_wsel, rf_wdat,
                 7 + i, 32'hC0DE_0000 + i);
      end
    end
    b_valid = 0;
    tick();
    total++;
    if (rf_wen !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got=%0b exp=0", rf_wen);
    end
  endtask

  task automatic test_scoreboard();
    for (int r = 0; r < 2; r++) begin
      rsv_en = 1; rsv_sel = 10;
      tick();
      rsv_en = 0;
      total++;
      if (busy[10] !== 1'b1) begin
        bad++;
        $display("FAIL sb_set%0d got=%0b exp=1", r, busy[10]);
      end
      a_valid = 1; a_sel = 10; a_dat = 32'h1000_0000 + r;
      tick();
      a_valid = 0;
      // Second round re-reserves on the same edge that retires the write.
      if (r == 1) begin
        rsv_en = 1; rsv_sel = 10;
      end
      tick();
      rsv_en = 0;
      total++;
      if (busy[10] !== (r == 1)) begin
        bad++;
        $display("FAIL sb_clear%0d got=%0b exp=%0b", r, busy[10], (r == 1));
      end
    end
    // Write to a non-busy register leaves the scoreboard alone.
    a_valid = 1; a_sel = 11; a_dat = 32'h1111_1111;
    tick();
    a_valid = 0;
    tick();
    total++;
    if (busy !== (NREG'(1) << 10)) begin
      bad++;
      $display("FAIL sb_nonbusy got=%h exp=%h", busy, NREG'(1) << 10);
    end
  endtask

  task automatic test_x0();
    a_valid = 1; a_sel = 0; a_dat = 32'hFFFF_FFFF;
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL x0_ready got=%0b exp=1", a_ready);
    end
    tick();
    a_valid = 0;
    total++;
    if (rf_wen !== 1'b0) begin
      bad++;
      $display("FAIL x0_wen got=%0b exp=0", rf_wen);
    end
    rsv_en = 1; rsv_sel = 0;
    tick();
    rsv_en = 0;
    total++;
    if (busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL x0_busy got=%0b exp=0", busy[0]);
    end
  endtask

  task automatic test_flush();
    rsv_en = 1; rsv_sel = 4;
    tick();
    rsv_sel = 6;
    tick();
    rsv_en = 0;
    total++;
    if (busy !== ((NREG'(1) << 4) | (NREG'(1) << 6) | (NREG'(1) << 10))) begin
      bad++;
      $display("FAIL flush_pre got=%h exp=%h", busy,
               (NREG'(1) << 4) | (NREG'(1) << 6) | (NREG'(1) << 10));
    end
    a_valid = 1; a_sel = 12; a_dat = 32'h0000_0C0C;
    flush = 1; rsv_en = 1; rsv_sel = 7;
    #1;
    total++;
    if (a_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%0b exp=0", a_ready);
    end
    tick();
    flush = 0; rsv_en = 0;
    total++;
    if (busy !== '0 || rf_wen !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear got=%h/%0b exp=0/0", busy, rf_wen);
    end
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_resume got=%0b exp=1", a_ready);
    end
    tick();
    a_valid = 0;
    total++;
    if (rf_wen !== 1'b1 || rf_wsel !== 5'd12 || rf_wdat !== 32'h0000_0C0C) begin
      bad++;
      $display("FAIL flush_after got=%0b/%0d/%h exp=1/12/00000c0c", rf_wen, rf_wsel, rf_wdat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_scoreboard();
    test_x0();
    test_flush();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
